// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state, RV32I
// funct3 width codes and the sign/zero extension helpers used by the lanes.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int BYTE_W     = 8;
  localparam int HALF_W     = 16;
  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'd0, b};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] h);
    return {16'd0, h};
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte/half formatting: load extraction with extension,
// sub-word store merge into a memory word, and the alignment check.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;
  logic              is_b, is_h, is_w;

  assign is_b = (funct3[1:0] == F3_B[1:0]);
  assign is_h = (funct3[1:0] == F3_H[1:0]);
  assign is_w = (funct3[1:0] == F3_W[1:0]);

  assign byte_sel   = word[{addr_lo, 3'b000} +: BYTE_W];
  assign half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
  assign misaligned = (is_h && addr_lo[0]) || (is_w && (addr_lo != 2'b00));

  always_comb begin
    load_val = word;
    case (funct3)
      F3_B:    load_val = sext8(byte_sel);
      F3_BU:   load_val = zext8(byte_sel);
      F3_H:    load_val = sext16(half_sel);
      F3_HU:   load_val = zext16(half_sel);
      default: load_val = word;
    endcase
  end

  // Only SB/SH reach the merge; full-word stores bypass this lane.
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_merge
    logic hit;
    assign hit = (is_b && (addr_lo == 2'(i))) || (is_h && (addr_lo[1] == 1'(i / 2)));
    assign merged[BYTE_W*i +: BYTE_W] = hit ? (is_b ? wdata[7:0] : wdata[BYTE_W*(i%2) +: BYTE_W])
                                            : word[BYTE_W*i +: BYTE_W];
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter onto a word-only memory; sub-word stores use read-modify-write.
// Define LSU_RANGE_CHECK_EN to reject word indices >= MEM_WORDS as errors.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wdata_q;

  logic [2:0]  lane_f3;
  logic [1:0]  lane_addr;
  logic [31:0] load_val, merged;
  logic        misaligned, illegal, out_of_range, bad, accept;

  // In IDLE the lane classifies the live request; afterwards it works on the latched copy.
  assign lane_f3   = (state == IDLE) ? req_funct3    : f3_q;
  assign lane_addr = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

  lsu_byte_lane u_lane (
    .funct3     (lane_f3),
    .addr_lo    (lane_addr),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .merged     (merged),
    .misaligned (misaligned)
  );

  assign illegal      = req_we ? (req_funct3 > F3_W)
                               : ((req_funct3 == 3'd3) || (req_funct3 > F3_HU));
  assign out_of_range = RANGE_EN && ({2'b00, req_addr[31:2]} >= MEM_WORDS);
  assign bad          = illegal || misaligned || out_of_range;
  assign accept       = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f3_q       <= '0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          if (accept) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we) begin
              state    <= LOAD;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
            end else if (req_funct3 == F3_W) begin
              state     <= WRITE;
              mem_write <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
            end else begin
              state    <= RMW_RD;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          mem_read   <= 1'b0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= load_val;
        end
        RMW_RD: begin
          state     <= WRITE;
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_wdata <= merged;
        end
        WRITE: begin
          state      <= RESP;
          mem_write  <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed scoreboard bench for lsu_mem_adapter with a behavioural word memory.
module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;

  lsu_mem_adapter #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_resp: observed response with empty scoreboard");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                        output int wr, output int rd, output logic [31:0] rd_addr);
    int lat;
    exp_t e;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    e.err = exp_err; e.rdata = exp_rdata;
    sb.push_back(e);
    lat = 0; wr = 0; rd = 0; rd_addr = '0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_write) wr++;
      if (mem_read) begin rd++; rd_addr = mem_addr; end
      if (resp_valid) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int wr, rd, n;
    logic [31:0] ra;

    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk) rst = 1'b0;

    do_req("sw0", 1'b1, 3'd2, 32'h00, 32'hA5A5A5A5, 1'b0, 32'h0, 2, wr, rd, ra);
    do_req("sw", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, wr, rd, ra);
    chk("sw_wr_pulse", 32'(wr), 32'd1);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);
    do_req("lw", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, wr, rd, ra);

    do_req("sw_pre", 1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, wr, rd, ra);
    do_req("sb", 1'b1, 3'd0, 32'h11, 32'h00000080, 1'b0, 32'h0, 3, wr, rd, ra);
    chk("sb_rd_wr", {16'(rd), 16'(wr)}, {16'd1, 16'd1});
    chk("sb_mem4", mem[4], 32'h11228044);
    do_req("lb", 1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 32'hFFFFFF80, 2, wr, rd, ra);
    do_req("lbu", 1'b0, 3'd4, 32'h11, 32'h0, 1'b0, 32'h00000080, 2, wr, rd, ra);

    do_req("sh", 1'b1, 3'd1, 32'h12, 32'h1234BEEF, 1'b0, 32'h0, 3, wr, rd, ra);
    chk("sh_mem4", mem[4], 32'hBEEF8044);
    do_req("lh", 1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2, wr, rd, ra);
    do_req("lhu", 1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h0000BEEF, 2, wr, rd, ra);

    do_req("lw_mis", 1'b0, 3'd2, 32'h06, 32'h0, 1'b1, 32'h0, 1, wr, rd, ra);
    chk("lw_mis_noacc", {16'(rd), 16'(wr)}, 32'd0);
    do_req("sh_mis", 1'b1, 3'd1, 32'h03, 32'h5555, 1'b1, 32'h0, 1, wr, rd, ra);
    chk("sh_mis_noacc", {16'(rd), 16'(wr)}, 32'd0);
    do_req("ld_f3", 1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0, 1, wr, rd, ra);
    do_req("st_f3", 1'b1, 3'd4, 32'h10, 32'h0, 1'b1, 32'h0, 1, wr, rd, ra);
    chk("st_f3_noacc", {16'(rd), 16'(wr)}, 32'd0);
    chk("err_mem4", mem[4], 32'hBEEF8044);

`ifdef LSU_RANGE_CHECK_EN
    do_req("range", 1'b0, 3'd2, 32'h80, 32'h0, 1'b1, 32'h0, 1, wr, rd, ra);
    chk("range_noacc", 32'(rd), 32'd0);
`else
    do_req("range", 1'b0, 3'd2, 32'h80, 32'h0, 1'b0, 32'hA5A5A5A5, 2, wr, rd, ra);
    chk("range_mem_addr", ra, 32'h80);
`endif

    // Abort an SB while its WRITE is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rmw_rd", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    chk("abort_write", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_drop", {31'd0, mem_write}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem4", mem[4], 32'hBEEF8044);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_no_resp", 32'(n), 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
